// File: rtl/pe_pkg.sv
// Shared widths, control-bit layout and lane helpers for the packed/wide MAC PE.
package pe_pkg;

    localparam int unsigned A_W         = 24;
    localparam int unsigned B_W         = 18;
    localparam int unsigned LANE_W      = 16;
    localparam int unsigned OUT_W       = 4 * LANE_W;
    localparam int unsigned N_LANES     = 4;
    localparam int unsigned LANE_PROD_W = 32;
    localparam int unsigned CTRL_W      = 4;

    localparam int unsigned CTRL_VALID = 0;
    localparam int unsigned CTRL_FIRST = 1;
    localparam int unsigned CTRL_LAST  = 2;
    localparam int unsigned CTRL_MODE  = 3;

    localparam logic MODE_WIDE   = 1'b0;
    localparam logic MODE_PACKED = 1'b1;

    typedef struct packed {
        logic mode;
        logic last;
        logic first;
        logic valid;
    } ctrl_t;

    // Fits a signed lane product into one accumulator lane (wraps if wider).
    function automatic logic [LANE_W-1:0] lane_sext(input logic signed [LANE_PROD_W-1:0] p);
        return LANE_W'(p);
    endfunction

endpackage

// File: rtl/pe_packed_mult.sv
// S1 multiplier: one wide signed product or four packed lane products, registered.
module pe_packed_mult
    import pe_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             mode,
    input  logic [A_W-1:0]   a,
    input  logic [B_W-1:0]   b,
    output logic [OUT_W-1:0] prod
);

    localparam int unsigned AH = A_W / 2;
    localparam int unsigned BH = B_W / 2;

    logic [OUT_W-1:0] prod_c;

    always_comb begin
        prod_c = '0;
        if (mode == MODE_WIDE) begin
            prod_c = OUT_W'($signed(a)) * OUT_W'($signed(b));
        end else begin
            // Lane ij lands at (2i+j); each lane wraps on its own.
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < 2; j++) begin
                    prod_c[(2*i+j)*LANE_W +: LANE_W] =
                        lane_sext(LANE_PROD_W'($signed(a[i*AH +: AH])) *
                                  LANE_PROD_W'($signed(b[j*BH +: BH])));
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod <= '0;
        end else if (en) begin
            prod <= prod_c;
        end
    end

endmodule

// File: rtl/pe_op_acc_stream.sv
// Systolic PE with operand passthrough, framed wide/packed MAC, buffered result
// port and sticky overflow/mode error flags.
module pe_op_acc_stream
    import pe_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [A_W-1:0]    up,
    input  logic [B_W-1:0]    left,
    input  logic              valid_in,
    input  logic              first,
    input  logic              last,
    input  logic              mode,
    output logic [A_W-1:0]    bottom,
    output logic [B_W-1:0]    right,
    output logic [CTRL_W-1:0] ctrl_right,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [OUT_W-1:0]  res_data,
    output logic              ovf_err,
    output logic              mode_err,
    input  logic              clr_err
);

    logic [CTRL_W-1:0] ctrl_c;
    ctrl_t             s1;
    logic              s1_eff_mode;
    logic              grp_mode;
    logic              eff_mode_c;
    logic [OUT_W-1:0]  prod;
    logic [OUT_W-1:0]  acc;
    logic [OUT_W-1:0]  acc_next;
    logic              mode_bad_c;
    logic              wr_c;
    logic              pop_c;
    logic              ovf_set_c;
    logic              mode_set_c;

    always_comb begin
        ctrl_c             = '0;
        ctrl_c[CTRL_VALID] = valid_in;
        ctrl_c[CTRL_FIRST] = first;
        ctrl_c[CTRL_LAST]  = last;
        ctrl_c[CTRL_MODE]  = mode;
    end

    // A group's arithmetic follows the mode latched on its first beat.
    assign eff_mode_c = (valid_in && first) ? mode : grp_mode;

    pe_packed_mult u_mult (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .mode  (eff_mode_c),
        .a     (up),
        .b     (left),
        .prod  (prod)
    );

    always_comb begin
        acc_next   = acc;
        mode_bad_c = 1'b0;
        if (s1.valid) begin
            if (s1.first) begin
                acc_next = prod;
            end else begin
                mode_bad_c = (s1.mode != s1_eff_mode);
                if (s1_eff_mode == MODE_WIDE) begin
                    acc_next = acc + prod;
                end else begin
                    for (int k = 0; k < N_LANES; k++) begin
                        acc_next[k*LANE_W +: LANE_W] = acc[k*LANE_W +: LANE_W] + prod[k*LANE_W +: LANE_W];
                    end
                end
            end
        end
    end

    assign wr_c       = en && s1.valid && s1.last;
    assign pop_c      = res_valid && res_ready;
    assign ovf_set_c  = wr_c && res_valid && !res_ready;
    assign mode_set_c = en && mode_bad_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bottom      <= '0;
            right       <= '0;
            ctrl_right  <= '0;
            s1          <= '0;
            s1_eff_mode <= MODE_WIDE;
            grp_mode    <= MODE_WIDE;
            acc         <= '0;
            res_data    <= '0;
            res_valid   <= 1'b0;
            ovf_err     <= 1'b0;
            mode_err    <= 1'b0;
        end else begin
            if (en) begin
                bottom      <= up;
                right       <= left;
                ctrl_right  <= ctrl_c;
                s1          <= ctrl_t'(ctrl_c);
                s1_eff_mode <= eff_mode_c;
                if (valid_in && first) begin
                    grp_mode <= mode;
                end
                acc <= acc_next;
            end
            // Result buffer: a write always lands, a pop only empties if no write.
            if (wr_c) begin
                res_data  <= acc_next;
                res_valid <= 1'b1;
            end else if (pop_c) begin
                res_valid <= 1'b0;
            end
            ovf_err  <= ovf_set_c  || (ovf_err  && !clr_err);
            mode_err <= mode_set_c || (mode_err && !clr_err);
        end
    end

endmodule
